// File: rtl/mux_arb_pkg.sv
// Shared types and helpers for the two-requester packet arbiter.
// State encoding, requester index type and counter sizing live here.
package mux_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } arb_state_t;

  typedef logic req_idx_t;

  function automatic int beat_cnt_width(input int max_beats);
    return $clog2(max_beats + 1);
  endfunction

  function automatic arb_state_t grant_state(input req_idx_t idx);
    return idx ? GRANT1 : GRANT0;
  endfunction

endpackage

// File: rtl/mux_w.sv
// Purely combinational 2:1 mux of {last, data}; zero latency, no flow control of its own.
module mux_w #(
  parameter int W = 9
) (
  input  logic         i_sel,
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic [W-1:0] o_y
);

  assign o_y = i_sel ? i_b : i_a;

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin 2:1 packet arbiter; grant at the edge after a request, data path combinational.
// Backpressure: out_ready passes straight to the granted requester's ready; the other sees 0.
module mux_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MAX_BEATS = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_valid,
  input  logic [1:0]       req_last,
  input  logic [WIDTH-1:0] req_data0,
  input  logic [WIDTH-1:0] req_data1,
  output logic [1:0]       req_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  input  logic             out_ready,
  output logic             sel,
  output logic             busy,
  output logic             err_overrun
);

  localparam int            CW       = beat_cnt_width(MAX_BEATS);
  localparam logic [CW-1:0] LAST_CNT = CW'(MAX_BEATS - 1);

  arb_state_t    r_state, w_state_nxt;
  req_idx_t      r_prio, w_prio_nxt;
  req_idx_t      r_sel, w_sel_nxt;
  logic [CW-1:0] r_beat_cnt, w_cnt_nxt;
  logic          r_err, w_err_nxt;

  req_idx_t   w_gnt;
  req_idx_t   w_oth;
  logic       w_busy;
  logic       w_beat;
  logic       w_cap;
  logic       w_eop;
  logic [WIDTH:0] w_mux;

  assign w_busy = (r_state != IDLE);
  assign w_gnt  = (r_state == GRANT1);
  assign w_oth  = ~w_gnt;
  assign w_beat = w_busy & req_valid[w_gnt] & out_ready;
  assign w_cap  = (r_beat_cnt == LAST_CNT);
  assign w_eop  = w_beat & (req_last[w_gnt] | w_cap);

  mux_w #(.W(WIDTH + 1)) u_mux (
    .i_sel (r_sel),
    .i_a   ({req_last[0], req_data0}),
    .i_b   ({req_last[1], req_data1}),
    .o_y   (w_mux)
  );

  assign busy        = w_busy;
  assign sel         = r_sel;
  assign err_overrun = r_err;
  assign out_valid   = w_busy & req_valid[w_gnt];
  assign out_last    = w_busy & w_mux[WIDTH];
  assign out_data    = w_busy ? w_mux[WIDTH-1:0] : '0;

  always_comb begin
    req_ready = 2'b00;
    if (w_busy) req_ready[w_gnt] = out_ready;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_prio_nxt  = r_prio;
    w_sel_nxt   = r_sel;
    w_cnt_nxt   = r_beat_cnt;
    w_err_nxt   = 1'b0;
    unique case (r_state)
      IDLE: begin
        unique case (req_valid)
          2'b01:   w_state_nxt = GRANT0;
          2'b10:   w_state_nxt = GRANT1;
          2'b11:   w_state_nxt = grant_state(r_prio);
          default: w_state_nxt = IDLE;
        endcase
      end
      default: begin
        if (w_beat) w_cnt_nxt = r_beat_cnt + 1'b1;
        // A beat implies the owner is still valid, so it keeps the grant when the peer is idle.
        if (w_eop) begin
          w_cnt_nxt  = '0;
          w_prio_nxt = w_oth;
          w_err_nxt  = w_cap & ~req_last[w_gnt];
          if (req_valid[w_oth])      w_state_nxt = grant_state(w_oth);
          else if (req_valid[w_gnt]) w_state_nxt = grant_state(w_gnt);
          else                       w_state_nxt = IDLE;
        end
      end
    endcase
    if (w_state_nxt != IDLE) w_sel_nxt = (w_state_nxt == GRANT1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_prio     <= 1'b0;
      r_sel      <= 1'b0;
      r_beat_cnt <= '0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_prio     <= w_prio_nxt;
      r_sel      <= w_sel_nxt;
      r_beat_cnt <= w_cnt_nxt;
      r_err      <= w_err_nxt;
    end
  end

endmodule
